// File: rtl/mem_master_pkg.sv
// Shared types and encodings for the mem_master SRAM bus controller.
package SLC3PP_2;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } mem_state_t;

    // Active-low memory strobes, grouped so one register holds the whole bus phase.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } mem_ctrl_t;

    localparam mem_ctrl_t CTRL_OFF   = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
    localparam mem_ctrl_t CTRL_READ  = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
    localparam mem_ctrl_t CTRL_WRITE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};

    function automatic mem_ctrl_t ctrl_for(input mem_state_t s);
        case (s)
            READ:    return CTRL_READ;
            WRITE:   return CTRL_WRITE;
            default: return CTRL_OFF;
        endcase
    endfunction

    // Only the first 256-word page window (addr[15:8] == 0) is backed by memory.
    function automatic logic page_ok(input logic [7:0] page);
        return page == '0;
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// CPU-side request/response handshake of mem_master.
interface mem_master_if;
    import SLC3PP_2::*;

    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;
    logic              busy;

    modport master (
        output req, rw, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, rw, addr, wdata,
        output rdata, ready, err, busy
    );

endinterface

// File: rtl/mem_master.sv
// Asynchronous SRAM bus master: one CPU access at a time with WAIT_STATES extra
// bus cycles; accesses outside the backed page complete with err and no bus cycle.
module mem_master
    import SLC3PP_2::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_master_if.slave       cpu,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] I_O
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    mem_state_t        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    mem_ctrl_t         ctrl_q, ctrl_d;
    logic              drive_q, drive_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ctrl_q  <= CTRL_OFF;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
            drive_q <= drive_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cpu.req) begin
                    if (page_ok(cpu.addr[15:8])) begin
                        a_d     = cpu.addr;
                        wdata_d = cpu.wdata;
                        cnt_d   = WAIT_LOAD;
                        err_d   = 1'b0;
                        state_d = cpu.rw ? WRITE : READ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            READ, WRITE: begin
                if (cnt_q == '0) begin
                    if (state_q == READ) begin
                        rdata_d = I_O;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes are registered from the next state so they line up with the state register.
        ctrl_d  = ctrl_for(state_d);
        drive_d = (state_d == WRITE);
    end

    assign CE  = ctrl_q.ce_n;
    assign OE  = ctrl_q.oe_n;
    assign WE  = ctrl_q.we_n;
    assign A   = a_q;
    assign I_O = drive_q ? wdata_q : 'z;

    assign cpu.rdata = rdata_q;
    assign cpu.ready = (state_q == DONE);
    assign cpu.err   = (state_q == DONE) && err_q;
    assign cpu.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: directed table, multi-cycle corner sequences,
// and randomized accesses against a transaction-level memory/rdata model.
module tb_mem_master;

    logic        clk;
    logic        rst_n;
    logic        req, rw;
    logic [31:0] addr, wdata;
    int          sel;

    int checks = 0;
    int errors = 0;

    mem_master_if bus0 ();
    mem_master_if bus3 ();

    logic        ce_w0, oe_w0, we_w0, ce_w3, oe_w3, we_w3;
    logic [31:0] a_w0, a_w3;
    wire  [31:0] io_w0, io_w3;

    assign bus0.req   = req && (sel == 0);
    assign bus0.rw    = rw;
    assign bus0.addr  = addr;
    assign bus0.wdata = wdata;
    assign bus3.req   = req && (sel == 1);
    assign bus3.rw    = rw;
    assign bus3.addr  = addr;
    assign bus3.wdata = wdata;

    mem_master #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst_n), .cpu(bus0.slave),
        .CE(ce_w0), .OE(oe_w0), .WE(we_w0), .A(a_w0), .I_O(io_w0)
    );

    mem_master #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst_n), .cpu(bus3.slave),
        .CE(ce_w3), .OE(oe_w3), .WE(we_w3), .A(a_w3), .I_O(io_w3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-level SRAM models (256 words, indexed by A[7:0]) with a preload port.
    logic [31:0] bmem0 [256];
    logic [31:0] bmem3 [256];
    logic        ld_en;
    logic [7:0]  ld_a;
    logic [31:0] ld_d;

    assign io_w0 = (!ce_w0 && !oe_w0 && we_w0) ? bmem0[a_w0[7:0]] : 32'bz;
    assign io_w3 = (!ce_w3 && !oe_w3 && we_w3) ? bmem3[a_w3[7:0]] : 32'bz;

    always @(posedge clk) begin
        if (ld_en) begin
            bmem0[ld_a] <= ld_d;
            bmem3[ld_a] <= ld_d;
        end else begin
            if (!ce_w0 && !we_w0) bmem0[a_w0[7:0]] <= io_w0;
            if (!ce_w3 && !we_w3) bmem3[a_w3[7:0]] <= io_w3;
        end
    end

    // Observation mux for the DUT currently selected by sel.
    logic        o_ce, o_we, o_ready, o_err, o_busy;
    logic [31:0] o_a, o_rdata;
    assign o_ce    = (sel != 0) ? ce_w3      : ce_w0;
    assign o_we    = (sel != 0) ? we_w3      : we_w0;
    assign o_a     = (sel != 0) ? a_w3       : a_w0;
    assign o_ready = (sel != 0) ? bus3.ready : bus0.ready;
    assign o_err   = (sel != 0) ? bus3.err   : bus0.err;
    assign o_busy  = (sel != 0) ? bus3.busy  : bus0.busy;
    assign o_rdata = (sel != 0) ? bus3.rdata : bus0.rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Protocol monitor on both controllers every cycle.
    always @(negedge clk) begin
        checks += 4;
        if (!we_w0 && !oe_w0) begin
            errors++;
            $display("FAIL oe_we_overlap_ws0: OE=%b WE=%b expected not both 0", oe_w0, we_w0);
        end
        if (!we_w3 && !oe_w3) begin
            errors++;
            $display("FAIL oe_we_overlap_ws3: OE=%b WE=%b expected not both 0", oe_w3, we_w3);
        end
        if (bus0.err && !bus0.ready) begin
            errors++;
            $display("FAIL err_without_ready_ws0: err=1 ready=0 expected err=0");
        end
        if (bus3.err && !bus3.ready) begin
            errors++;
            $display("FAIL err_without_ready_ws3: err=1 ready=0 expected err=0");
        end
        if (we_w0 && !(!ce_w0 && !oe_w0)) begin
            checks++;
            if (io_w0 !== 32'bz) begin
                errors++;
                $display("FAIL io_released_ws0: I_O=%h expected Z", io_w0);
            end
        end
        if (we_w3 && !(!ce_w3 && !oe_w3)) begin
            checks++;
            if (io_w3 !== 32'bz) begin
                errors++;
                $display("FAIL io_released_ws3: I_O=%h expected Z", io_w3);
            end
        end
    end

    // Transaction-level reference: per-DUT memory image and last successful read.
    logic [31:0] refm   [2][256];
    logic [31:0] ref_rd [2];

    function automatic void model(input int s, input logic r, input logic [31:0] ad,
                                  input logic [31:0] wd, output int lat, output logic e,
                                  output logic [31:0] rd, output int ce);
        bit ok;
        int ws;
        ok  = (ad[15:8] == 8'h00);
        ws  = (s != 0) ? 3 : 0;
        lat = ok ? ws + 2 : 1;
        ce  = ok ? ws + 1 : 0;
        e   = !ok;
        if (ok && r)  refm[s][ad[7:0]] = wd;
        if (ok && !r) ref_rd[s] = refm[s][ad[7:0]];
        rd = ref_rd[s];
    endfunction

    task automatic run_txn(input int s, input logic r, input logic [31:0] ad, input logic [31:0] wd,
                           output int lat, output logic e, output logic [31:0] rd, output int ce_lo);
        bit got;
        @(negedge clk);
        sel = s; req = 1'b1; rw = r; addr = ad; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; ce_lo = 0; got = 0; e = 1'b0; rd = '0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!o_ce) begin
                ce_lo++;
                chk("addr_bus", o_a, ad);
            end
            if (o_ready) begin
                got = 1;
                e   = o_err;
                rd  = o_rdata;
            end
        end
        chk("ready_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("ready_one_cycle", 32'(o_ready), 32'd0);
        chk("busy_after_done", 32'(o_busy), 32'd0);
    endtask

    task automatic exec(input int s, input logic r, input logic [31:0] ad, input logic [31:0] wd);
        int lat, ce, elat, ece;
        logic e, ee;
        logic [31:0] rd, erd;
        run_txn(s, r, ad, wd, lat, e, rd, ce);
        model(s, r, ad, wd, elat, ee, erd, ece);
        chk("latency", lat, elat);
        chk("err", 32'(e), 32'(ee));
        chk("rdata", rd, erd);
        chk("ce_cycles", ce, ece);
    endtask

    typedef struct {
        int          s;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_ce;
    } vec_t;

    vec_t tbl [8];

    initial begin : main
        int lat, ce, k, pulses, mlat, mce;
        logic e, me;
        logic [31:0] rd, mrd, v, tmp, ad;
        bit got;

        tbl[0] = '{0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1};
        tbl[1] = '{0, 1'b0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1};
        tbl[2] = '{0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b1, 1, 0};
        tbl[3] = '{1, 1'b0, 32'h0000_0019, 32'h0,         32'h43F4_69BA, 1'b0, 5, 4};
        tbl[4] = '{1, 1'b1, 32'hABCD_0019, 32'h1234_5678, 32'h43F4_69BA, 1'b0, 5, 4};
        tbl[5] = '{1, 1'b0, 32'hABCD_0019, 32'h0,         32'h1234_5678, 1'b0, 5, 4};
        tbl[6] = '{1, 1'b1, 32'h0000_FF00, 32'h5555_AAAA, 32'h1234_5678, 1'b1, 1, 0};
        tbl[7] = '{0, 1'b0, 32'h00FF_0105, 32'h0,         32'hDEAD_BEEF, 1'b1, 1, 0};

        req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sel = 0;
        ld_en = 1'b0; ld_a = '0; ld_d = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_CE_ws0", 32'(ce_w0), 32'd1);
        chk("rst_OE_ws0", 32'(oe_w0), 32'd1);
        chk("rst_WE_ws0", 32'(we_w0), 32'd1);
        chk("rst_A_ws0", a_w0, 32'd0);
        chk("rst_rdata_ws0", bus0.rdata, 32'd0);
        chk("rst_ready_ws0", 32'(bus0.ready), 32'd0);
        chk("rst_busy_ws0", 32'(bus0.busy), 32'd0);
        chk("rst_CE_ws3", 32'(ce_w3), 32'd1);
        chk("rst_WE_ws3", 32'(we_w3), 32'd1);
        chk("rst_A_ws3", a_w3, 32'd0);
        chk("rst_rdata_ws3", bus3.rdata, 32'd0);
        chk("rst_busy_ws3", 32'(bus3.busy), 32'd0);
        checks++;
        if (io_w0 !== 32'bz || io_w3 !== 32'bz) begin
            errors++;
            $display("FAIL rst_io_z: I_O=%h/%h expected Z", io_w0, io_w3);
        end

        ld_en = 1'b1;
        for (int unsigned i = 0; i < 256; i++) begin
            @(negedge clk);
            v = $urandom;
            if (i == 32'h19) v = 32'h43F4_69BA;
            refm[0][i] = v;
            refm[1][i] = v;
            ld_a = 8'(i);
            ld_d = v;
        end
        @(negedge clk);
        ld_en = 1'b0;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 8; i++) begin
            run_txn(tbl[i].s, tbl[i].rw, tbl[i].addr, tbl[i].wdata, lat, e, rd, ce);
            model(tbl[i].s, tbl[i].rw, tbl[i].addr, tbl[i].wdata, mlat, me, mrd, mce);
            chk("tbl_latency", lat, tbl[i].exp_lat);
            chk("tbl_err", 32'(e), 32'(tbl[i].exp_err));
            chk("tbl_rdata", rd, tbl[i].exp_rd);
            chk("tbl_ce_cycles", ce, tbl[i].exp_ce);
        end

        // Second request pulsed mid-READ must be dropped, not queued.
        @(negedge clk);
        sel = 1; req = 1'b1; rw = 1'b0; addr = 32'h0000_0022; wdata = '0;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("busy_in_read", 32'(o_busy), 32'd1);
        req = 1'b1; rw = 1'b1; addr = 32'h0000_0033; wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        req = 1'b0;
        pulses = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += int'(o_ready);
        end
        chk("ignored_req_pulses", pulses, 1);
        model(1, 1'b0, 32'h0000_0022, '0, mlat, me, mrd, mce);
        chk("ignored_req_rdata", o_rdata, mrd);
        exec(1, 1'b0, 32'h0000_0033, '0);

        // req held through DONE is taken on the next IDLE edge.
        @(negedge clk);
        sel = 0; req = 1'b1; rw = 1'b0; addr = 32'h0000_0005; wdata = '0;
        k = 0; got = 0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (o_ready) got = 1;
        end
        chk("held_first_latency", k, 2);
        model(0, 1'b0, 32'h0000_0005, '0, mlat, me, mrd, mce);
        chk("held_first_rdata", o_rdata, mrd);
        rw = 1'b1; addr = 32'h0000_0007; wdata = 32'h0F0F_1234;
        k = 0; got = 0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (o_busy) req = 1'b0;
            if (o_ready) got = 1;
        end
        req = 1'b0;
        chk("held_second_latency", k, 3);
        model(0, 1'b1, 32'h0000_0007, 32'h0F0F_1234, mlat, me, mrd, mce);
        exec(0, 1'b0, 32'h0000_0007, '0);

        // Reset in the middle of a WRITE, after one write edge has reached memory.
        @(negedge clk);
        sel = 1; req = 1'b1; rw = 1'b1; addr = 32'h0000_0040; wdata = 32'hC0FF_EE11;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("mid_write_we", 32'(o_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_CE", 32'(ce_w3), 32'd1);
        chk("abort_WE", 32'(we_w3), 32'd1);
        chk("abort_busy", 32'(bus3.busy), 32'd0);
        chk("abort_ready", 32'(bus3.ready), 32'd0);
        chk("abort_rdata", bus3.rdata, 32'd0);
        checks++;
        if (io_w3 !== 32'bz) begin
            errors++;
            $display("FAIL abort_io_z: I_O=%h expected Z", io_w3);
        end
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(bus3.ready), 32'd0);
        end
        rst_n = 1'b1;
        refm[1][8'h40] = 32'hC0FF_EE11;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        exec(1, 1'b0, 32'h0000_0040, '0);

        for (int unsigned n = 0; n < 80; n++) begin
            tmp = $urandom;
            if ($urandom_range(3, 0) != 0) begin
                ad = {tmp[31:16], 8'h00, 4'h0, tmp[3:0]};
            end else begin
                ad = tmp;
                if (ad[15:8] == 8'h00) ad[15:8] = 8'h5A;
            end
            exec(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ad, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
